rem3_tx: RTL and testbench
==========================

Name: rem3_tx

Overview:
- Serial mod-3 check transmitter: the sending end of the team's serial remainder-mod-3 link.
- Accepts a W-bit parallel word and shifts it out MSB-first on a one-bit line.
- Appends a 2-bit check symbol so the whole (W+2)-bit frame, read as an unsigned integer, is divisible by 3.
- The downstream remainder-checker FSM therefore reports remainder 00 at the end of every good frame.

Parameters:
- W, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  request to send din; accepted when start && ready on a clk edge.
- din  input  W  word to transmit; sampled only on acceptance.
- ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit, MSB-first data, then check bits (check[1] before check[0]).
- x_valid  output  1  x carries a frame bit this cycle.
- last  output  1  high with the final check bit (check[0]) of a frame.
- busy  output  1  frame in progress (x_valid mirror, kept for status).

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE; shift register and residue cleared.
  - x=0, x_valid=0, last=0, busy=0, ready=1.
  - If reset occurs mid-frame, the partial frame is abandoned with no further bits; after deassert, the block is ready on the first edge.
- All outputs are registered. ready is decoded combinationally from registered state.
- FSM states: IDLE, DATA, CHK1, CHK0.
- IDLE:
  - ready=1, x_valid=0.
  - On start: load din into shift register, clear residue r to 0, bit counter = W-1, go to DATA.
- DATA:
  - x = shreg[W-1], x_valid=1. Shift left each cycle.
  - Residue update per transmitted bit b: r <= (2*r + b) mod 3, with r encoded 00/01/10.
  - When counter reaches 0: compute final residue rf; check = (3 - rf) mod 3 (rf=0 -> 00, rf=1 -> 10, rf=2 -> 01); go to CHK1.
- CHK1: x = check[1], x_valid=1; go to CHK0.
- CHK0:
  - x = check[0], x_valid=1, last=1, ready=1.
  - On start: load the new word and go to DATA, giving back-to-back frames with zero idle cycles.
  - Otherwise go to IDLE.
- Latency: the first data bit appears on x in the cycle after acceptance. A frame occupies exactly W+2 consecutive x_valid cycles.
- start while ready=0 is ignored. din is not re-sampled mid-frame.
- Arithmetic: residue is always in {0,1,2}. Encoding 2'b11 is unreachable; if reached, it recovers to 0 with the next bit.
- Frame integer = din*4 + check ≡ din + check ≡ 0 (mod 3).
- Illegal state encoding: go to IDLE with outputs deasserted.

Optional Feature:
- Macro REM3_TX_ERR_INJECT_EN.
- Defined:
  - Adds input port err_inj (1 bit), sampled together with din on acceptance.
  - If set, the transmitted check = (correct check + 1) mod 3, so the frame remainder is nonzero and the receiver must flag it.
- Undefined: port absent; check is always correct.

Decomposition:
- Shared package rem3_pkg:
  - State encoding constants: IDLE=2'd0, DATA=2'd1, CHK1=2'd2, CHK0=2'd3.
  - Residue constants: R0=2'b00, R1=2'b01, R2=2'b10 (same encoding as the receiver's a/b/c states).
  - A function giving the next residue for (r, bit).
- Sub-module rem3_resid: a registered residue tracker (clear, bit, enable -> r), reusable by the receiver side.
- Top-level rem3_tx holds the FSM, shift register and bit counter.

Test Plan:
- W=8, din=8'h07 (rf=1): x = 0,0,0,0,0,1,1,1,1,0 over 10 cycles; last on cycle 10; frame value 30, checker remainder 00.
- din=8'hA5 (165, rf=0): check 00, x = 1,0,1,0,0,1,0,1,0,0; din=8'h02 -> check 01.
- Back-to-back: start held high, din 8'h01 then 8'hFF: 20 contiguous x_valid cycles, ready=1 only in CHK0/IDLE, check bits 10 then 00.
- reset pulsed low at data bit 4: x_valid=0 immediately (asynchronously); next start with 8'h02 yields a clean frame, check 01.
- start asserted during DATA with a different din: ignored; current frame unchanged; ready=0 throughout.
- With REM3_TX_ERR_INJECT_EN, din=8'h07, err_inj=1: check 00 instead of 10; checker ends with remainder 01.

Source files
------------

// File: rtl/rem3_pkg.sv
// rem3_pkg: shared types and arithmetic for the serial remainder-mod-3 link.
// Contents: FSM state encoding, residue encoding (R0/R1/R2), residue step
// and check-symbol helpers used by both transmitter and receiver sides.
package rem3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CHK1 = 2'd2,
        CHK0 = 2'd3
    } state_t;

    // Residue encoding matches the receiver's a/b/c states.
    localparam logic [1:0] R0 = 2'b00;
    localparam logic [1:0] R1 = 2'b01;
    localparam logic [1:0] R2 = 2'b10;

    // Next residue after appending bit b: (2*r + b) mod 3.
    // The unreachable code 2'b11 is treated as R0 so it self-recovers.
    function automatic logic [1:0] next_resid(input logic [1:0] r, input logic b);
        case (r)
            R0:      return b ? R1 : R0;
            R1:      return b ? R0 : R2;
            R2:      return b ? R2 : R1;
            default: return b ? R1 : R0;
        endcase
    endfunction

    // Check symbol c with (rf + c) mod 3 == 0; the frame is data*4 + c and 4 == 1 mod 3.
    function automatic logic [1:0] check_of(input logic [1:0] rf);
        case (rf)
            R1:      return 2'b10;
            R2:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // (c + 1) mod 3, used to corrupt a check symbol on purpose.
    function automatic logic [1:0] check_inc(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rem3_resid.sv
// rem3_resid: registered running residue mod 3 of a MSB-first bit stream.
// Latency: o_r reflects a bit one cycle after it is presented with i_en.
// Backpressure: none; i_clr has priority over i_en.
// Ports: clk, rst_n (async active-low), i_clr, i_en, i_bit, o_r[1:0].
module rem3_resid
    import rem3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [1:0] o_r
);

    logic [1:0] r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= R0;
        end else if (i_clr) begin
            r_res <= R0;
        end else if (i_en) begin
            r_res <= next_resid(r_res, i_bit);
        end
    end

    assign o_r = r_res;

endmodule

// File: rtl/rem3_tx.sv
// rem3_tx: serial mod-3 check transmitter, W data bits MSB-first then 2 check bits.
// Latency: first data bit on x the cycle after start&&ready; frame is W+2 cycles.
// Backpressure: ready only in IDLE/CHK0; start while !ready is ignored.
// Ports: clk, reset (async active-low), start, din[W-1:0], [err_inj],
//        ready, x, x_valid, last, busy.
// Optional: define REM3_TX_ERR_INJECT_EN to add err_inj, which sends a
//           deliberately wrong check symbol for the accepted word.
module rem3_tx
    import rem3_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
`ifdef REM3_TX_ERR_INJECT_EN
    input  logic         err_inj,
`endif
    input  logic [W-1:0] din,
    output logic         ready,
    output logic         x,
    output logic         x_valid,
    output logic         last,
    output logic         busy
);

    localparam int CW = $clog2(W);

    state_t         r_state;
    logic [W-1:0]   r_shreg;
    logic [CW-1:0]  r_cnt;
    logic           r_chk0;
    logic           r_x;
    logic           r_vld;
    logic           r_last;
    logic           r_busy;

    logic           w_accept;
    logic [1:0]     w_res;
    logic [1:0]     w_rf;
    logic [1:0]     w_chk;

    assign ready    = (r_state == IDLE) || (r_state == CHK0);
    assign w_accept = start && ready;

    // Residue covers the bits already shown on x; the bit currently on x
    // is folded in as it leaves, so clear happens on acceptance.
    rem3_resid u_resid (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (w_accept),
        .i_en  (r_state == DATA),
        .i_bit (r_x),
        .o_r   (w_res)
    );

    // Final residue includes the last data bit still on x this cycle.
    assign w_rf = next_resid(w_res, r_x);

`ifdef REM3_TX_ERR_INJECT_EN
    logic r_err;
    assign w_chk = r_err ? check_inc(check_of(w_rf)) : check_of(w_rf);
`else
    assign w_chk = check_of(w_rf);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_chk0  <= 1'b0;
            r_x     <= 1'b0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef REM3_TX_ERR_INJECT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, CHK0: begin
                    if (w_accept) begin
                        // MSB goes straight to x; the shifter holds the rest.
                        r_state <= DATA;
                        r_x     <= din[W-1];
                        r_shreg <= {din[W-2:0], 1'b0};
                        r_cnt   <= CW'(W - 1);
                        r_vld   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= 1'b0;
`ifdef REM3_TX_ERR_INJECT_EN
                        r_err   <= err_inj;
`endif
                    end else begin
                        r_state <= IDLE;
                        r_x     <= 1'b0;
                        r_vld   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                DATA: begin
                    if (r_cnt == '0) begin
                        r_state <= CHK1;
                        r_x     <= w_chk[1];
                        r_chk0  <= w_chk[0];
                    end else begin
                        r_x     <= r_shreg[W-1];
                        r_shreg <= r_shreg << 1;
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                CHK1: begin
                    r_state <= CHK0;
                    r_x     <= r_chk0;
                    r_last  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_x     <= 1'b0;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign x       = r_x;
    assign x_valid = r_vld;
    assign last    = r_last;
    assign busy    = r_busy;

endmodule

// File: tb/tb_rem3_tx.sv
// tb_rem3_tx: directed, table-driven bench for rem3_tx with W=8.
// Latency: frames are captured from x_valid over a bounded cycle window.
// Backpressure: start is only driven while ready is expected high, except in
//               the sequence that deliberately pokes start mid-frame.
module tb_rem3_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] din;
    logic         ready;
    logic         x;
    logic         x_valid;
    logic         last;
    logic         busy;
`ifdef REM3_TX_ERR_INJECT_EN
    logic         err_inj;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rem3_tx #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
`ifdef REM3_TX_ERR_INJECT_EN
        .err_inj (err_inj),
`endif
        .din     (din),
        .ready   (ready),
        .x       (x),
        .x_valid (x_valid),
        .last    (last),
        .busy    (busy)
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] chk;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Sends one word from IDLE and captures up to 14 cycles of output.
    task automatic run_frame(input logic [7:0] d, output logic [9:0] frm,
                             output int nv, output int lastpos);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        @(negedge clk);
        start = 1'b0;
        din   = 8'h5A;
        frm = '0;
        nv = 0;
        lastpos = -1;
        for (int c = 0; c < 14; c++) begin
            if (x_valid) begin
                frm = {frm[8:0], x};
                nv++;
                if (last) lastpos = nv;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t        tv[8];
        logic [9:0]  frm;
        logic [9:0]  exp_frm;
        logic [19:0] fr20;
        logic [19:0] exp20;
        int          nv;
        int          lastpos;
        int          rdy_bad;
        int          bsy_bad;

        tv[0] = '{8'h07, 2'b10};
        tv[1] = '{8'hA5, 2'b00};
        tv[2] = '{8'h02, 2'b01};
        tv[3] = '{8'h01, 2'b10};
        tv[4] = '{8'hFF, 2'b00};
        tv[5] = '{8'h80, 2'b01};
        tv[6] = '{8'h00, 2'b00};
        tv[7] = '{8'h0B, 2'b01};

        reset = 1'b0;
        start = 1'b0;
        din   = '0;
`ifdef REM3_TX_ERR_INJECT_EN
        err_inj = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_ready",   32'(ready),   32'd1);
        chk("reset_x_valid", 32'(x_valid), 32'd0);
        chk("reset_x",       32'(x),       32'd0);
        chk("reset_last",    32'(last),    32'd0);
        chk("reset_busy",    32'(busy),    32'd0);
        reset = 1'b1;

        // Single frames from the table.
        for (int i = 0; i < 8; i++) begin
            run_frame(tv[i].d, frm, nv, lastpos);
            exp_frm = {tv[i].d, tv[i].chk};
            chk($sformatf("frame_bits[%0d]", i), 32'(frm), 32'(exp_frm));
            chk($sformatf("frame_len[%0d]", i),  32'(nv), 32'd10);
            chk($sformatf("last_pos[%0d]", i),   32'(lastpos), 32'd10);
            chk($sformatf("frame_mod3[%0d]", i), 32'(int'(frm) % 3), 32'd0);
        end

        // Back-to-back: start held high, 8'h01 then 8'hFF.
        @(negedge clk);
        start = 1'b1;
        din   = 8'h01;
        fr20 = '0;
        nv = 0;
        rdy_bad = 0;
        bsy_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) din = 8'hFF;
            if (x_valid) begin
                fr20 = {fr20[18:0], x};
                nv++;
            end
            if (ready !== ((i == 9) || (i == 19))) rdy_bad++;
            if (busy !== x_valid) bsy_bad++;
            if (i == 19) start = 1'b0;
        end
        exp20 = {8'h01, 2'b10, 8'hFF, 2'b00};
        chk("b2b_bits",      32'(fr20), 32'(exp20));
        chk("b2b_valid_cnt", 32'(nv), 32'd20);
        chk("b2b_ready",     32'(rdy_bad), 32'd0);
        chk("b2b_busy",      32'(bsy_bad), 32'd0);
        @(negedge clk);
        chk("b2b_end_valid", 32'(x_valid), 32'd0);
        chk("b2b_end_ready", 32'(ready), 32'd1);

        // Start poked mid-frame with another word is ignored.
        start = 1'b1;
        din   = 8'hA5;
        frm = '0;
        nv = 0;
        rdy_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i >= 1) && (i <= 4);
            if (i >= 1) din = 8'h3C;
            if (x_valid) begin
                frm = {frm[8:0], x};
                nv++;
            end
            if (ready !== (i == 9)) rdy_bad++;
        end
        start = 1'b0;
        chk("poke_bits",  32'(frm), 32'({8'hA5, 2'b00}));
        chk("poke_len",   32'(nv), 32'd10);
        chk("poke_ready", 32'(rdy_bad), 32'd0);
        @(negedge clk);
        chk("poke_end_valid", 32'(x_valid), 32'd0);

        // Asynchronous reset at data bit 4 abandons the frame.
        start = 1'b1;
        din   = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 32'(x_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_valid", 32'(x_valid), 32'd0);
        chk("rst_async_busy",  32'(busy), 32'd0);
        chk("rst_async_ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        run_frame(8'h02, frm, nv, lastpos);
        chk("post_rst_bits", 32'(frm), 32'({8'h02, 2'b01}));
        chk("post_rst_len",  32'(nv), 32'd10);
        chk("post_rst_last", 32'(lastpos), 32'd10);

`ifdef REM3_TX_ERR_INJECT_EN
        err_inj = 1'b1;
        run_frame(8'h07, frm, nv, lastpos);
        err_inj = 1'b0;
        chk("inj_bits", 32'(frm), 32'({8'h07, 2'b00}));
        chk("inj_mod3", 32'(int'(frm) % 3), 32'd1);
        run_frame(8'h07, frm, nv, lastpos);
        chk("inj_off_bits", 32'(frm), 32'({8'h07, 2'b10}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
